// File: rtl/umi_mem_tester.sv
// UMI host-side memory tester: writes a seeded pattern to a UMI device, reads it back and checks it.
// Define UMI_TESTER_POSTED_EN to issue posted writes (REQ_POSTED, no write responses awaited).
module umi_mem_tester #(
  parameter int CW      = 32,
  parameter int AW      = 64,
  parameter int DW      = 256,
  parameter int CNTW    = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [AW-1:0]   host_addr,
  input  logic [CNTW-1:0] count,
  input  logic [31:0]     seed,
  output logic            uhost_req_valid,
  output logic [CW-1:0]   uhost_req_cmd,
  output logic [AW-1:0]   uhost_req_dstaddr,
  output logic [AW-1:0]   uhost_req_srcaddr,
  output logic [DW-1:0]   uhost_req_data,
  input  logic            uhost_req_ready,
  input  logic            uhost_resp_valid,
  input  logic [CW-1:0]   uhost_resp_cmd,
  input  logic [AW-1:0]   uhost_resp_dstaddr,
  input  logic [AW-1:0]   uhost_resp_srcaddr,
  input  logic [DW-1:0]   uhost_resp_data,
  output logic            uhost_resp_ready,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [CNTW-1:0] err_count
);

  localparam logic [4:0] OP_REQ_READ   = 5'h01;
  localparam logic [4:0] OP_REQ_WRITE  = 5'h03;
  localparam logic [4:0] OP_REQ_POSTED = 5'h05;
  localparam logic [4:0] OP_RESP_READ  = 5'h02;
  localparam logic [4:0] OP_RESP_WRITE = 5'h04;
  localparam int         BSH           = $clog2(DW/8);
  localparam logic [31:0] TMO_LAST     = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

`ifdef UMI_TESTER_POSTED_EN
  localparam logic [4:0] OP_WR = OP_REQ_POSTED;
`else
  localparam logic [4:0] OP_WR = OP_REQ_WRITE;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_DONE
  } state_e;

  function automatic logic [CW-1:0] mk_cmd(input logic [4:0] op);
    logic [CW-1:0] c;
    c        = '0;
    c[4:0]   = op;
    c[7:5]   = 3'd3;
    c[15:8]  = 8'(DW/64 - 1);
    c[22]    = 1'b1;
    return c;
  endfunction

  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a, input logic [1:0] n);
    logic [CNTW:0] s;
    s = {1'b0, a} + (CNTW+1)'(n);
    return s[CNTW] ? '1 : s[CNTW-1:0];
  endfunction

  state_e          state_q;
  logic [CNTW-1:0] k_q, count_q, err_q;
  logic [AW-1:0]   base_q, host_q;
  logic [31:0]     seed_q, tmo_q;
  logic            tmo_flag_q;
  logic            req_valid_q;
  logic [CW-1:0]   req_cmd_q;
  logic [AW-1:0]   req_dst_q, req_src_q;
  logic [DW-1:0]   req_data_q;

  logic [CNTW:0]   k_inc_d;
  logic            last_d;
  logic [AW-1:0]   word_addr_d;
  logic [DW-1:0]   word_data_d;
  logic [1:0]      fails_d;
  logic            rd_phase_d;

  // Word-k addressing/pattern and response checks, all derived from registered state.
  always_comb begin
    k_inc_d     = {1'b0, k_q} + (CNTW+1)'(1);
    last_d      = (k_inc_d == {1'b0, count_q});
    word_addr_d = base_q + (AW'(k_q) << BSH);
    word_data_d = {(DW/32){seed_q + 32'(k_q)}};
    rd_phase_d  = (state_q == S_RD_RESP);
    fails_d     = 2'({1'b0, uhost_resp_cmd[4:0] != (rd_phase_d ? OP_RESP_READ : OP_RESP_WRITE)})
                + 2'({1'b0, uhost_resp_dstaddr != host_q})
                + 2'({1'b0, rd_phase_d && (uhost_resp_data != word_data_d)});
  end

  // NOTE: all state here is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking ones would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      count_q     <= '0;
      err_q       <= '0;
      base_q      <= '0;
      host_q      <= '0;
      seed_q      <= '0;
      tmo_q       <= '0;
      tmo_flag_q  <= 1'b0;
      req_valid_q <= 1'b0;
      req_cmd_q   <= '0;
      req_dst_q   <= '0;
      req_src_q   <= '0;
      req_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            base_q     <= base_addr;
            host_q     <= host_addr;
            count_q    <= count;
            seed_q     <= seed;
            k_q        <= '0;
            err_q      <= '0;
            tmo_flag_q <= 1'b0;
            state_q    <= (count == '0) ? S_DONE : S_WR_REQ;
          end
        end
        S_WR_REQ, S_RD_REQ: begin
          // Fields load one cycle after entry and are frozen until the handshake.
          if (!req_valid_q) begin
            req_valid_q <= 1'b1;
            req_cmd_q   <= mk_cmd((state_q == S_WR_REQ) ? OP_WR : OP_REQ_READ);
            req_dst_q   <= word_addr_d;
            req_src_q   <= host_q;
            req_data_q  <= (state_q == S_WR_REQ) ? word_data_d : '0;
          end else if (uhost_req_ready) begin
            req_valid_q <= 1'b0;
            tmo_q       <= '0;
            if (state_q == S_RD_REQ) begin
              state_q <= S_RD_RESP;
            end else begin
`ifdef UMI_TESTER_POSTED_EN
              k_q     <= last_d ? '0 : k_inc_d[CNTW-1:0];
              state_q <= last_d ? S_RD_REQ : S_WR_REQ;
`else
              state_q <= S_WR_RESP;
`endif
            end
          end
        end
        S_WR_RESP, S_RD_RESP: begin
          if (uhost_resp_valid) begin
            err_q <= sat_add(err_q, fails_d);
            k_q   <= last_d ? '0 : k_inc_d[CNTW-1:0];
            if (rd_phase_d) state_q <= last_d ? S_DONE : S_RD_REQ;
            else            state_q <= last_d ? S_RD_REQ : S_WR_REQ;
          end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
            tmo_flag_q <= 1'b1;
            err_q      <= sat_add(err_q, 2'd1);
            state_q    <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign uhost_req_valid   = req_valid_q;
  assign uhost_req_cmd     = req_cmd_q;
  assign uhost_req_dstaddr = req_dst_q;
  assign uhost_req_srcaddr = req_src_q;
  assign uhost_req_data    = req_data_q;
  assign uhost_resp_ready  = (state_q == S_WR_RESP) || (state_q == S_RD_RESP);
  assign busy              = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done              = (state_q == S_DONE);
  assign timeout           = tmo_flag_q;
  assign err_count         = err_q;
  assign pass              = done && (err_q == '0) && !tmo_flag_q;

  logic unused_ok;
  assign unused_ok = ^{uhost_resp_srcaddr, uhost_resp_cmd[CW-1:5]};

endmodule

// File: tb/tb_umi_mem_tester.sv
// Directed bench for umi_mem_tester: a negedge-driven ideal UMI RAM model plus a vector table
// and hand-written reset / count=0 / start-while-busy sequences.
`timescale 1ns/1ps
module tb_umi_mem_tester;
  localparam int CW = 32, AW = 64, DW = 256, CNTW = 16, TMO = 16;
`ifdef UMI_TESTER_POSTED_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif
  localparam logic [31:0] CMD_WR     = POSTED ? 32'h0040_0365 : 32'h0040_0363;
  localparam logic [31:0] CMD_RD     = 32'h0040_0361;
  localparam logic [31:0] CMD_RSP_WR = 32'h0040_0364;
  localparam logic [31:0] CMD_RSP_RD = 32'h0040_0362;

  typedef struct {
    logic [31:0]  cmd;
    logic [63:0]  dst;
    logic [255:0] data;
  } rsp_t;

  typedef struct {
    int          cnt;
    logic [63:0] base;
    logic [63:0] host;
    logic [31:0] seed;
    int          bp;
    int          drop;
    int          bad_dst;
    int          corrupt;
    int          exp_err;
    bit          exp_pass;
    bit          exp_tmo;
    int          exp_wr;
    int          exp_rd;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset, start;
  logic [AW-1:0]   base_addr, host_addr;
  logic [CNTW-1:0] count;
  logic [31:0]     seed;
  logic            uhost_req_valid, uhost_req_ready;
  logic [CW-1:0]   uhost_req_cmd;
  logic [AW-1:0]   uhost_req_dstaddr, uhost_req_srcaddr;
  logic [DW-1:0]   uhost_req_data;
  logic            uhost_resp_valid, uhost_resp_ready;
  logic [CW-1:0]   uhost_resp_cmd;
  logic [AW-1:0]   uhost_resp_dstaddr, uhost_resp_srcaddr;
  logic [DW-1:0]   uhost_resp_data;
  logic            busy, done, pass, timeout;
  logic [CNTW-1:0] err_count;

  always #5 clk = ~clk;

  umi_mem_tester #(.CW(CW), .AW(AW), .DW(DW), .CNTW(CNTW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .host_addr(host_addr), .count(count), .seed(seed),
    .uhost_req_valid(uhost_req_valid), .uhost_req_cmd(uhost_req_cmd),
    .uhost_req_dstaddr(uhost_req_dstaddr), .uhost_req_srcaddr(uhost_req_srcaddr),
    .uhost_req_data(uhost_req_data), .uhost_req_ready(uhost_req_ready),
    .uhost_resp_valid(uhost_resp_valid), .uhost_resp_cmd(uhost_resp_cmd),
    .uhost_resp_dstaddr(uhost_resp_dstaddr), .uhost_resp_srcaddr(uhost_resp_srcaddr),
    .uhost_resp_data(uhost_resp_data), .uhost_resp_ready(uhost_resp_ready),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model state and transaction logs
  logic [255:0] mem [logic [63:0]];
  rsp_t         rspq[$];
  logic [63:0]  wr_addr[$], rd_addr[$];
  logic [31:0]  wr_cmd[$], rd_cmd[$];
  logic [255:0] wr_data[$];
  int  bp, drop_idx, bad_dst_idx, corrupt_rd, rsp_idx, stall_err, valid_cycles, drop_cyc, rsp_wait;
  bit  hold_rd, flush, resp_fire, prev_stall;
  logic [31:0]  s_cmd;
  logic [63:0]  s_dst, s_src;
  logic [255:0] s_data;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_rsp(input logic [31:0] cmd, input logic [63:0] dst, input logic [255:0] data);
    rsp_t r;
    if (rsp_idx == drop_idx) begin
      drop_cyc = cyc;
    end else begin
      r.cmd  = cmd;
      r.dst  = (rsp_idx == bad_dst_idx) ? (dst ^ 64'h10) : dst;
      r.data = data;
      rspq.push_back(r);
    end
    rsp_idx++;
  endtask

  // Model: decides ready/valid at negedge, so everything it sees is stable until the next posedge.
  initial begin
    logic [255:0] rd;
    uhost_req_ready    = 1'b0;
    uhost_resp_valid   = 1'b0;
    uhost_resp_cmd     = '0;
    uhost_resp_dstaddr = '0;
    uhost_resp_srcaddr = '0;
    uhost_resp_data    = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && (!uhost_req_valid || uhost_req_cmd !== s_cmd || uhost_req_dstaddr !== s_dst ||
                         uhost_req_srcaddr !== s_src || uhost_req_data !== s_data))
        stall_err++;
      if (resp_fire) begin
        rspq.delete(0);
        uhost_resp_valid = 1'b0;
      end
      if (flush) begin
        rspq.delete();
        uhost_resp_valid = 1'b0;
        flush = 1'b0;
      end
      if (!uhost_resp_valid && rspq.size() > 0 && !(hold_rd && rspq[0].cmd == CMD_RSP_RD)) begin
        if (bp == 0 || rsp_wait >= 4 || $urandom_range(0, 2) == 0) begin
          uhost_resp_valid   = 1'b1;
          uhost_resp_cmd     = rspq[0].cmd;
          uhost_resp_dstaddr = rspq[0].dst;
          uhost_resp_data    = rspq[0].data;
          rsp_wait = 0;
        end else begin
          rsp_wait++;
        end
      end
      uhost_req_ready = (bp == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      if (uhost_req_valid) valid_cycles++;
      if (uhost_req_valid && uhost_req_ready && !reset) begin
        case (uhost_req_cmd[4:0])
          5'h03, 5'h05: begin
            wr_addr.push_back(uhost_req_dstaddr);
            wr_cmd.push_back(uhost_req_cmd);
            wr_data.push_back(uhost_req_data);
            mem[uhost_req_dstaddr] = uhost_req_data;
            if (uhost_req_cmd[4:0] == 5'h03) push_rsp(CMD_RSP_WR, uhost_req_srcaddr, '0);
          end
          5'h01: begin
            rd = mem.exists(uhost_req_dstaddr) ? mem[uhost_req_dstaddr] : '0;
            if (rd_addr.size() == corrupt_rd) rd[0] = ~rd[0];
            rd_addr.push_back(uhost_req_dstaddr);
            rd_cmd.push_back(uhost_req_cmd);
            push_rsp(CMD_RSP_RD, uhost_req_srcaddr, rd);
          end
          default: ;
        endcase
      end
      prev_stall = uhost_req_valid && !uhost_req_ready && !reset;
      s_cmd  = uhost_req_cmd;
      s_dst  = uhost_req_dstaddr;
      s_src  = uhost_req_srcaddr;
      s_data = uhost_req_data;
      resp_fire = uhost_resp_valid && uhost_resp_ready && !reset;
    end
  end

  task automatic clear_model(input int b, input int drop, input int bdst, input int corr, input bit hold);
    wr_addr.delete(); rd_addr.delete(); wr_cmd.delete(); rd_cmd.delete(); wr_data.delete();
    bp = b; drop_idx = drop; bad_dst_idx = bdst; corrupt_rd = corr; hold_rd = hold;
    rsp_idx = 0; stall_err = 0; valid_cycles = 0; drop_cyc = -1; rsp_wait = 0;
  endtask

  task automatic pulse_start(input logic [63:0] b, input logic [63:0] h, input int c, input logic [31:0] s);
    @(negedge clk);
    base_addr = b; host_addr = h; count = CNTW'(c); seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int tmo_cyc);
    ok = 1'b0;
    tmo_cyc = -1;
    for (int c = 0; c < budget; c++) begin
      if (timeout && tmo_cyc < 0) tmo_cyc = cyc;
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit ok;
    int tc, perr;
    logic [31:0] p;
    clear_model(v.bp, v.drop, v.bad_dst, v.corrupt, 1'b0);
    pulse_start(v.base, v.host, v.cnt, v.seed);
    wait_done(20000, ok, tc);
    check($sformatf("v%0d done reached", idx), ok, 1);
    check($sformatf("v%0d err_count", idx), err_count, v.exp_err);
    check($sformatf("v%0d pass", idx), pass, v.exp_pass);
    check($sformatf("v%0d timeout", idx), timeout, v.exp_tmo);
    check($sformatf("v%0d busy", idx), busy, 0);
    check($sformatf("v%0d writes", idx), wr_addr.size(), v.exp_wr);
    check($sformatf("v%0d reads", idx), rd_addr.size(), v.exp_rd);
    check($sformatf("v%0d stall stability", idx), stall_err, 0);
    perr = 0;
    for (int k = 0; k < wr_addr.size(); k++) begin
      p = v.seed + 32'(k);
      if (wr_addr[k] !== v.base + 64'(k) * 64'd32 || wr_data[k] !== {8{p}} || wr_cmd[k] !== CMD_WR) perr++;
    end
    for (int k = 0; k < rd_addr.size(); k++)
      if (rd_addr[k] !== v.base + 64'(k) * 64'd32 || rd_cmd[k] !== CMD_RD) perr++;
    check($sformatf("v%0d addr/data/cmd pattern", idx), perr, 0);
    if (v.exp_tmo) check($sformatf("v%0d timeout latency", idx), (tc - drop_cyc >= 16) && (tc - drop_cyc <= 17), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    bit ok;
    int tc, bad;
    reset = 1'b1; start = 1'b0; base_addr = '0; host_addr = '0; count = '0; seed = '0;
    clear_model(0, -1, -1, -1, 1'b0);
    flush = 1'b0;

    repeat (3) @(negedge clk);
    check("reset flags/err", {busy, done, pass, timeout, uhost_req_valid, uhost_resp_ready, err_count}, 0);
    check("reset req cmd/addr", {uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr}, 0);
    check("reset req data", uhost_req_data, 0);
    reset = 1'b0;

    vecs[0] = '{4,  64'h100, 64'hF000, 32'hA5A5_0000, 0, -1, -1, -1, 0, 1'b1, 1'b0, 4, 4};
    vecs[1] = '{64, 64'h2000, 64'h1234_0000, 32'hDEAD_0000, 1, -1, -1, -1, 0, 1'b1, 1'b0, 64, 64};
    vecs[2] = '{4,  64'h100, 64'hF000, 32'h1111_0000, 0, -1, -1, 2, 1, 1'b0, 1'b0, 4, 4};
    vecs[3] = '{4,  64'h300, 64'hF000, 32'h2222_0000, 0, 2, -1, -1, 1, 1'b0, 1'b1,
                POSTED ? 4 : 3, POSTED ? 3 : 0};
    vecs[4] = '{3,  64'h500, 64'hABC0, 32'h3333_0000, 1, -1, 1, -1, 1, 1'b0, 1'b0, 3, 3};
    vecs[5] = '{2,  64'hFFFF_FFFF_FFFF_FFE0, 64'h40, 32'hFFFF_FFFF, 0, -1, -1, -1, 0, 1'b1, 1'b0, 2, 2};
    vecs[6] = '{8,  64'h1000, 64'h77, 32'h0000_0000, 1, -1, -1, -1, 0, 1'b1, 1'b0, 8, 8};

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
      if (i == 0) begin
        check("v0 write addr 1", wr_addr[1], 64'h120);
        check("v0 write addr 3", wr_addr[3], 64'h160);
        check("v0 write cmd", wr_cmd[0], CMD_WR);
        check("v0 read cmd", rd_cmd[0], 32'h0040_0361);
        check("v0 write data 2", wr_data[2], {8{32'hA5A5_0002}});
        check("v0 srcaddr", uhost_req_srcaddr, 64'hF000);
      end
    end

    // count = 0: immediate done/pass, no traffic
    clear_model(0, -1, -1, -1, 1'b0);
    pulse_start(64'h100, 64'hF000, 0, 32'h1);
    check("count0 done next cycle", done, 1);
    check("count0 pass", pass, 1);
    repeat (5) @(negedge clk);
    check("count0 no req_valid", valid_cycles, 0);

    // start while busy is ignored
    clear_model(0, -1, -1, -1, 1'b0);
    pulse_start(64'h400, 64'hF000, 4, 32'h4444_0000);
    repeat (3) @(negedge clk);
    pulse_start(64'h800, 64'hF000, 1, 32'h9999_0000);
    wait_done(2000, ok, tc);
    check("busy start done", ok, 1);
    check("busy start writes", wr_addr.size(), 4);
    check("busy start last addr", wr_addr[3], 64'h460);
    check("busy start pass", pass, 1);

    // reset during RD_RESP, late response ignored, then restart
    clear_model(0, -1, -1, -1, 1'b1);
    pulse_start(64'h800, 64'hF000, 4, 32'h5555_0000);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (uhost_resp_ready && rd_addr.size() > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reached RD_RESP", ok, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid reset flags/err", {busy, done, pass, timeout, uhost_req_valid, uhost_resp_ready, err_count}, 0);
    check("mid reset req cmd/addr", {uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr}, 0);
    check("mid reset req data", uhost_req_data, 0);
    hold_rd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (uhost_resp_ready || busy || uhost_req_valid || !uhost_resp_valid) bad++;
    end
    check("late response ignored", bad, 0);
    flush = 1'b1;
    repeat (2) @(negedge clk);
    clear_model(0, -1, -1, -1, 1'b0);
    pulse_start(64'h900, 64'hF000, 2, 32'h6666_0000);
    wait_done(2000, ok, tc);
    check("restart done", ok, 1);
    check("restart pass", pass, 1);
    check("restart reads", rd_addr.size(), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
